// File: rtl/simon_dec.sv
`timescale 1ns/1ps
// rtl/simon_dec.sv - Iterative Simon 32/64 decryption core with optional tail-key cache.
module simon_dec #(
    parameter int KEY_CACHE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ciphertext,
    input  logic [63:0] keytext,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] plaintext,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DECRYPT, S_DONE} state_t;

    // Leftmost character of the z0 sequence is index 0, so it sits at the MSB.
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;

    function automatic logic z_bit(input logic [5:0] idx);
        return (idx < 6'd62) ? Z0[6'd61 - idx] : 1'b0;
    endfunction

    function automatic logic [15:0] f_round(input logic [15:0] v);
        return ({v[14:0], v[15]} & {v[7:0], v[15:8]}) ^ {v[13:0], v[15:14]};
    endfunction

    // Same expression serves both directions: far is k[i] going forward, k[i+4] going back.
    function automatic logic [15:0] key_step(input logic [15:0] k_far,
                                             input logic [15:0] k_near1,
                                             input logic [15:0] k_near3,
                                             input logic        zb);
        logic [15:0] tmp;
        tmp = {k_near3[2:0], k_near3[15:3]} ^ k_near1;
        tmp = tmp ^ {tmp[0], tmp[15:1]};
        return ~k_far ^ tmp ^ {15'd0, zb} ^ 16'd3;
    endfunction

    state_t             r_state;
    logic [4:0]         r_cnt;
    logic [15:0]        r_x;
    logic [15:0]        r_y;
    logic [3:0][15:0]   r_k;
    logic [63:0]        r_key;
    logic [31:0]        r_pt;
    logic [3:0][15:0]   r_cache_k;
    logic [63:0]        r_cache_key;
    logic               r_cache_valid;

    logic        w_hit;
    logic        w_z_fwd;
    logic        w_z_inv;
    logic [15:0] w_k_fwd;
    logic [15:0] w_k_inv;
    logic [15:0] w_y_next;

    assign w_hit    = (KEY_CACHE != 0) && r_cache_valid && (keytext == r_cache_key);
    assign w_z_fwd  = z_bit({1'b0, r_cnt});
    // Window holds k[i-3..i]; recovering k[i-4] needs z[i-4] (garbage for i<4 is never used).
    assign w_z_inv  = z_bit({1'b0, r_cnt} - 6'd4);
    assign w_k_fwd  = key_step(r_k[0], r_k[1], r_k[3], w_z_fwd);
    assign w_k_inv  = key_step(r_k[3], r_k[0], r_k[2], w_z_inv);
    assign w_y_next = r_x ^ f_round(r_y) ^ r_k[3];

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_EXPAND) || (r_state == S_DECRYPT);
    assign plaintext = r_pt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= 5'd0;
            r_x           <= 16'd0;
            r_y           <= 16'd0;
            r_k           <= '0;
            r_key         <= 64'd0;
            r_pt          <= 32'd0;
            r_cache_k     <= '0;
            r_cache_key   <= 64'd0;
            r_cache_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x   <= ciphertext[31:16];
                        r_y   <= ciphertext[15:0];
                        r_key <= keytext;
                        if (w_hit) begin
                            r_k     <= r_cache_k;
                            r_cnt   <= 5'd31;
                            r_state <= S_DECRYPT;
                        end else begin
                            r_k     <= keytext;
                            r_cnt   <= 5'd0;
                            r_state <= S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
                    r_k <= {w_k_fwd, r_k[3], r_k[2], r_k[1]};
                    if (r_cnt == 5'd27) begin
                        if (KEY_CACHE != 0) begin
                            r_cache_k     <= {w_k_fwd, r_k[3], r_k[2], r_k[1]};
                            r_cache_key   <= r_key;
                            r_cache_valid <= 1'b1;
                        end
                        r_cnt   <= 5'd31;
                        r_state <= S_DECRYPT;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DECRYPT: begin
                    r_x <= r_y;
                    r_y <= w_y_next;
                    r_k <= {r_k[2], r_k[1], r_k[0], w_k_inv};
                    if (r_cnt == 5'd0) begin
                        r_pt    <= {r_y, w_y_next};
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
